// File: rtl/tl_xbar_1ton.sv
// ----------------------------------------------------------------------------
// tl_xbar_1ton
//
// Purpose:
//   Single-client to NUM_OUT-manager TileLink-UL crossbar.
//   - A channel: routed combinationally by the address select field
//     in_a_address[SEL_LSB +: SEL_W]. Select values >= NUM_OUT fold onto the
//     last port. All A fields are broadcast; only out_a_valid is steered.
//   - D channel: responses from the managers are merged through a
//     round-robin arbiter. Once a multi-beat response wins, the grant stays
//     locked on that port until its last beat has been accepted.
//
// Handshake semantics (both channels): a beat transfers in a cycle where
//   valid && ready are both high. The crossbar never holds a beat of its own;
//   ready is passed straight through from the selected sink.
//
// Optional build macro:
//   TLXBAR_A_BURST_LOCK_EN - when defined, a multi-beat Put (opcode[2]==0,
//   size > LGB) latches its route on the first A beat and keeps it for the
//   remaining beats regardless of the address bits. When undefined the A
//   route is purely combinational from the address every cycle.
//
// Ports:
//   clock, reset            clock, synchronous active-high reset
//   in_a_*                  client A channel (valid/ready + fields)
//   in_d_*                  client D channel (valid/ready + fields)
//   out_a_*                 per-manager A channel, port k at [k*W +: W]
//   out_d_*                 per-manager D channel, port k at [k*W +: W]
// ----------------------------------------------------------------------------
module tl_xbar_1ton #(
    parameter int NUM_OUT    = 2,
    parameter int SEL_LSB    = 16,
    parameter int ADDR_W     = 21,
    parameter int DATA_W     = 64,
    parameter int SRC_W      = 7,
    parameter int SIZE_W     = 3,
    localparam int SEL_W      = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1,
    localparam int BEAT_BYTES = DATA_W / 8,
    localparam int LGB        = $clog2(BEAT_BYTES)
) (
    input  logic                           clock,
    input  logic                           reset,

    // Client A channel
    input  logic                           in_a_valid,
    output logic                           in_a_ready,
    input  logic [2:0]                     in_a_opcode,
    input  logic [2:0]                     in_a_param,
    input  logic [SIZE_W-1:0]              in_a_size,
    input  logic [SRC_W-1:0]               in_a_source,
    input  logic [ADDR_W-1:0]              in_a_address,
    input  logic [BEAT_BYTES-1:0]          in_a_mask,
    input  logic [DATA_W-1:0]              in_a_data,
    input  logic                           in_a_corrupt,

    // Client D channel
    output logic                           in_d_valid,
    input  logic                           in_d_ready,
    output logic [2:0]                     in_d_opcode,
    output logic [SIZE_W-1:0]              in_d_size,
    output logic [SRC_W-1:0]               in_d_source,
    output logic [DATA_W-1:0]              in_d_data,

    // Manager A channels
    output logic [NUM_OUT-1:0]             out_a_valid,
    input  logic [NUM_OUT-1:0]             out_a_ready,
    output logic [3*NUM_OUT-1:0]           out_a_opcode,
    output logic [3*NUM_OUT-1:0]           out_a_param,
    output logic [SIZE_W*NUM_OUT-1:0]      out_a_size,
    output logic [SRC_W*NUM_OUT-1:0]       out_a_source,
    output logic [ADDR_W*NUM_OUT-1:0]      out_a_address,
    output logic [BEAT_BYTES*NUM_OUT-1:0]  out_a_mask,
    output logic [DATA_W*NUM_OUT-1:0]      out_a_data,
    output logic [NUM_OUT-1:0]             out_a_corrupt,

    // Manager D channels
    input  logic [NUM_OUT-1:0]             out_d_valid,
    output logic [NUM_OUT-1:0]             out_d_ready,
    input  logic [3*NUM_OUT-1:0]           out_d_opcode,
    input  logic [SIZE_W*NUM_OUT-1:0]      out_d_size,
    input  logic [SRC_W*NUM_OUT-1:0]       out_d_source,
    input  logic [DATA_W*NUM_OUT-1:0]      out_d_data
);

    localparam logic [SIZE_W-1:0] LGB_S    = SIZE_W'(LGB);
    localparam logic [SEL_W-1:0]  LAST_IDX = SEL_W'(NUM_OUT - 1);

    // Number of beats minus one for a message of the given size. Only
    // messages that carry data and exceed one beat are multi-beat. The shift
    // may wrap to zero for the largest size; the subtraction then still
    // yields the correct all-ones count.
    function automatic logic [SIZE_W:0] beats_m1(input logic multi,
                                                 input logic [SIZE_W-1:0] size);
        logic [SIZE_W:0] one_hot;
        one_hot  = '0;
        beats_m1 = '0;
        if (multi && (size > LGB_S)) begin
            one_hot  = (SIZE_W+1)'(1) << (size - LGB_S);
            beats_m1 = one_hot - (SIZE_W+1)'(1);
        end
    endfunction

    // ------------------------------------------------------------------
    // A channel routing
    // ------------------------------------------------------------------
    logic [SEL_W-1:0]   sel_raw;
    logic [SEL_W-1:0]   route_addr;
    logic [SEL_W-1:0]   route;
    logic [NUM_OUT-1:0] route_oh;

    assign sel_raw    = in_a_address[SEL_LSB +: SEL_W];
    // Unused select codes fold onto the highest port.
    assign route_addr = (sel_raw > LAST_IDX) ? LAST_IDX : sel_raw;

`ifdef TLXBAR_A_BURST_LOCK_EN
    logic [SIZE_W:0]  a_beats_left_q, a_beats_left_d;
    logic [SEL_W-1:0] a_route_q, a_route_d;
    logic             a_fire;
    logic             a_multi_put;

    assign a_fire      = in_a_valid & in_a_ready;
    assign a_multi_put = ~in_a_opcode[2];

    // While beats of a Put burst remain, the latched route wins over the
    // address so a burst cannot be split across managers.
    assign route = (a_beats_left_q != '0) ? a_route_q : route_addr;

    always_comb begin
        a_beats_left_d = a_beats_left_q;
        a_route_d      = a_route_q;
        if (a_fire) begin
            if (a_beats_left_q == '0) begin
                a_beats_left_d = beats_m1(a_multi_put, in_a_size);
                a_route_d      = route_addr;
            end else begin
                a_beats_left_d = a_beats_left_q - (SIZE_W+1)'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            a_beats_left_q <= '0;
            a_route_q      <= '0;
        end else begin
            a_beats_left_q <= a_beats_left_d;
            a_route_q      <= a_route_d;
        end
    end
`else
    assign route = route_addr;
`endif

    always_comb begin
        route_oh = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            route_oh[k] = (route == SEL_W'(k));
        end
    end

    assign out_a_valid   = {NUM_OUT{in_a_valid}} & route_oh;
    assign in_a_ready    = |(out_a_ready & route_oh);

    assign out_a_opcode  = {NUM_OUT{in_a_opcode}};
    assign out_a_param   = {NUM_OUT{in_a_param}};
    assign out_a_size    = {NUM_OUT{in_a_size}};
    assign out_a_source  = {NUM_OUT{in_a_source}};
    assign out_a_address = {NUM_OUT{in_a_address}};
    assign out_a_mask    = {NUM_OUT{in_a_mask}};
    assign out_a_data    = {NUM_OUT{in_a_data}};
    assign out_a_corrupt = {NUM_OUT{in_a_corrupt}};

    // ------------------------------------------------------------------
    // D channel arbitration
    // ------------------------------------------------------------------
    logic [SIZE_W:0]    beats_left_q, beats_left_d;
    logic [NUM_OUT-1:0] state_q, state_d;
    logic [SEL_W-1:0]   prio_q, prio_d;

    logic               idle;
    logic [NUM_OUT-1:0] at_or_above;
    logic [NUM_OUT-1:0] req_hi;
    logic [NUM_OUT-1:0] pick_from;
    logic [NUM_OUT-1:0] winner;
    logic [SEL_W-1:0]   win_idx;
    logic [NUM_OUT-1:0] mux_sel;
    logic               any_valid;

    assign idle      = (beats_left_q == '0);
    assign any_valid = |out_d_valid;

    // Round-robin: first valid port at or above the pointer; if none, the
    // search wraps to the lowest valid port below it.
    always_comb begin
        at_or_above = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            at_or_above[k] = (int'(prio_q) <= k);
        end
    end

    assign req_hi    = out_d_valid & at_or_above;
    assign pick_from = (|req_hi) ? req_hi : out_d_valid;

    always_comb begin
        winner  = '0;
        win_idx = '0;
        for (int k = NUM_OUT - 1; k >= 0; k--) begin
            if (pick_from[k]) begin
                winner    = '0;
                winner[k] = 1'b1;
                win_idx   = SEL_W'(k);
            end
        end
    end

    assign mux_sel     = idle ? winner : state_q;
    assign in_d_valid  = idle ? any_valid : |(out_d_valid & state_q);
    assign out_d_ready = {NUM_OUT{in_d_ready}} & mux_sel;

    // AND-OR field mux; all zero when nothing is selected.
    always_comb begin
        in_d_opcode = '0;
        in_d_size   = '0;
        in_d_source = '0;
        in_d_data   = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            in_d_opcode = in_d_opcode | ({3{mux_sel[k]}}      & out_d_opcode[k*3 +: 3]);
            in_d_size   = in_d_size   | ({SIZE_W{mux_sel[k]}} & out_d_size[k*SIZE_W +: SIZE_W]);
            in_d_source = in_d_source | ({SRC_W{mux_sel[k]}}  & out_d_source[k*SRC_W +: SRC_W]);
            in_d_data   = in_d_data   | ({DATA_W{mux_sel[k]}} & out_d_data[k*DATA_W +: DATA_W]);
        end
    end

    // While idle the muxed fields belong to the winner, so its beat count can
    // be taken from the merged opcode/size. With no winner they are zero and
    // the count stays zero.
    always_comb begin
        beats_left_d = beats_left_q;
        state_d      = state_q;
        prio_d       = prio_q;
        if (idle) begin
            state_d = winner;
            if (in_d_ready) begin
                beats_left_d = beats_m1(in_d_opcode[0], in_d_size);
                if (any_valid) begin
                    prio_d = (win_idx == LAST_IDX) ? '0 : win_idx + SEL_W'(1);
                end
            end
        end else if (in_d_valid && in_d_ready) begin
            beats_left_d = beats_left_q - (SIZE_W+1)'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            beats_left_q <= '0;
            state_q      <= '0;
            prio_q       <= '0;
        end else begin
            beats_left_q <= beats_left_d;
            state_q      <= state_d;
            prio_q       <= prio_d;
        end
    end

endmodule

// File: tb/tb_tl_xbar_1ton.sv
// ----------------------------------------------------------------------------
// tb_tl_xbar_1ton
//
// Self-checking bench for tl_xbar_1ton with four managers. Directed steps
// cover reset, round-robin order, A routing and stall, locked bursts,
// mid-burst valid drop, reset mid-burst and the optional A burst lock;
// a randomized phase follows. Every cycle's outputs are compared with a
// transaction-level model (lock owner, beats remaining, pointer) kept here.
// ----------------------------------------------------------------------------
module tb_tl_xbar_1ton;

    localparam int N       = 4;
    localparam int SEL_LSB = 16;
    localparam int ADDR_W  = 21;
    localparam int DATA_W  = 64;
    localparam int SRC_W   = 7;
    localparam int SIZE_W  = 3;
    localparam int BB      = DATA_W / 8;
    localparam int LGB     = 3;

    logic                   clock;
    logic                   reset;
    logic                   in_a_valid;
    logic                   in_a_ready;
    logic [2:0]             in_a_opcode;
    logic [2:0]             in_a_param;
    logic [SIZE_W-1:0]      in_a_size;
    logic [SRC_W-1:0]       in_a_source;
    logic [ADDR_W-1:0]      in_a_address;
    logic [BB-1:0]          in_a_mask;
    logic [DATA_W-1:0]      in_a_data;
    logic                   in_a_corrupt;
    logic                   in_d_valid;
    logic                   in_d_ready;
    logic [2:0]             in_d_opcode;
    logic [SIZE_W-1:0]      in_d_size;
    logic [SRC_W-1:0]       in_d_source;
    logic [DATA_W-1:0]      in_d_data;
    logic [N-1:0]           out_a_valid;
    logic [N-1:0]           out_a_ready;
    logic [3*N-1:0]         out_a_opcode;
    logic [3*N-1:0]         out_a_param;
    logic [SIZE_W*N-1:0]    out_a_size;
    logic [SRC_W*N-1:0]     out_a_source;
    logic [ADDR_W*N-1:0]    out_a_address;
    logic [BB*N-1:0]        out_a_mask;
    logic [DATA_W*N-1:0]    out_a_data;
    logic [N-1:0]           out_a_corrupt;
    logic [N-1:0]           out_d_valid;
    logic [N-1:0]           out_d_ready;
    logic [3*N-1:0]         out_d_opcode;
    logic [SIZE_W*N-1:0]    out_d_size;
    logic [SRC_W*N-1:0]     out_d_source;
    logic [DATA_W*N-1:0]    out_d_data;

    tl_xbar_1ton #(
        .NUM_OUT (N),
        .SEL_LSB (SEL_LSB),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .SRC_W   (SRC_W),
        .SIZE_W  (SIZE_W)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .in_a_valid    (in_a_valid),
        .in_a_ready    (in_a_ready),
        .in_a_opcode   (in_a_opcode),
        .in_a_param    (in_a_param),
        .in_a_size     (in_a_size),
        .in_a_source   (in_a_source),
        .in_a_address  (in_a_address),
        .in_a_mask     (in_a_mask),
        .in_a_data     (in_a_data),
        .in_a_corrupt  (in_a_corrupt),
        .in_d_valid    (in_d_valid),
        .in_d_ready    (in_d_ready),
        .in_d_opcode   (in_d_opcode),
        .in_d_size     (in_d_size),
        .in_d_source   (in_d_source),
        .in_d_data     (in_d_data),
        .out_a_valid   (out_a_valid),
        .out_a_ready   (out_a_ready),
        .out_a_opcode  (out_a_opcode),
        .out_a_param   (out_a_param),
        .out_a_size    (out_a_size),
        .out_a_source  (out_a_source),
        .out_a_address (out_a_address),
        .out_a_mask    (out_a_mask),
        .out_a_data    (out_a_data),
        .out_a_corrupt (out_a_corrupt),
        .out_d_valid   (out_d_valid),
        .out_d_ready   (out_d_ready),
        .out_d_opcode  (out_d_opcode),
        .out_d_size    (out_d_size),
        .out_d_source  (out_d_source),
        .out_d_data    (out_d_data)
    );

    // ---------------- clock ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- counters / model state ----------------
    int n_vec;
    int n_err;

    int m_left;     // D beats still owed by the locked port (0 = idle)
    int m_lock;     // locked D port
    int m_ptr;      // round-robin pointer
    int m_a_left;   // A beats remaining in a locked Put burst
    int m_a_route;  // route held by that burst

    logic [N-1:0] obs_d_ready;
    logic         obs_d_valid;
    logic [N-1:0] obs_a_valid;
    logic         obs_a_ready;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int d_beats(input logic [2:0] op, input logic [SIZE_W-1:0] size);
        if (op[0] && int'(size) > LGB) return 2 ** (int'(size) - LGB);
        return 1;
    endfunction

    function automatic int a_beats(input logic [2:0] op, input logic [SIZE_W-1:0] size);
        if (!op[2] && int'(size) > LGB) return 2 ** (int'(size) - LGB);
        return 1;
    endfunction

    // One clock cycle: inputs are already driven. Check outputs mid-cycle
    // against the model, then advance the model across the rising edge.
    task automatic do_cycle();
        int sel, route, win, g, j;
        logic exp_dv;
        logic [N-1:0] exp_dr;
        int nx_left, nx_lock, nx_ptr, nx_a_left, nx_a_route;

        #2;
        obs_d_ready = out_d_ready;
        obs_d_valid = in_d_valid;
        obs_a_valid = out_a_valid;
        obs_a_ready = in_a_ready;

        // A channel
        sel   = int'(in_a_address[SEL_LSB +: 2]);
        route = (sel > N - 1) ? N - 1 : sel;
        if (m_a_left > 0) route = m_a_route;
        chk("a_valid", out_a_valid, in_a_valid ? (N'(1) << route) : '0);
        chk("a_ready", in_a_ready, out_a_ready[route]);
        chk("a_addr",  out_a_address, {N{in_a_address}});
        chk("a_data",  out_a_data, {N{in_a_data}});
        chk("a_misc",  {out_a_opcode, out_a_param, out_a_size, out_a_source, out_a_mask, out_a_corrupt},
                       {{N{in_a_opcode}}, {N{in_a_param}}, {N{in_a_size}}, {N{in_a_source}},
                        {N{in_a_mask}}, {N{in_a_corrupt}}});

        // D channel
        win = -1;
        if (m_left == 0) begin
            for (int i = 0; i < N; i++) begin
                j = (m_ptr + i) % N;
                if (win < 0 && out_d_valid[j]) win = j;
            end
            g      = win;
            exp_dv = |out_d_valid;
        end else begin
            g      = m_lock;
            exp_dv = out_d_valid[m_lock];
        end
        exp_dr = (in_d_ready && g >= 0) ? (N'(1) << g) : '0;
        chk("d_valid", in_d_valid, exp_dv);
        chk("d_ready", out_d_ready, exp_dr);
        if (g >= 0) begin
            chk("d_fields", {in_d_opcode, in_d_size, in_d_source},
                {out_d_opcode[g*3 +: 3], out_d_size[g*SIZE_W +: SIZE_W], out_d_source[g*SRC_W +: SRC_W]});
            chk("d_data", in_d_data, out_d_data[g*DATA_W +: DATA_W]);
        end else begin
            chk("d_fields_zero", {in_d_opcode, in_d_size, in_d_source, in_d_data}, '0);
        end

        // Next model state
        nx_left = m_left; nx_lock = m_lock; nx_ptr = m_ptr;
        nx_a_left = m_a_left; nx_a_route = m_a_route;
        if (reset) begin
            nx_left = 0; nx_lock = 0; nx_ptr = 0; nx_a_left = 0; nx_a_route = 0;
        end else begin
            if (m_left == 0) begin
                nx_lock = win;
                if (in_d_ready) begin
                    nx_left = (win >= 0) ? d_beats(out_d_opcode[win*3 +: 3], out_d_size[win*SIZE_W +: SIZE_W]) - 1 : 0;
                    if (win >= 0) nx_ptr = (win + 1) % N;
                end
            end else if (exp_dv && in_d_ready) begin
                nx_left = m_left - 1;
            end
`ifdef TLXBAR_A_BURST_LOCK_EN
            if (in_a_valid && out_a_ready[route]) begin
                if (m_a_left == 0) begin
                    nx_a_left  = a_beats(in_a_opcode, in_a_size) - 1;
                    nx_a_route = route;
                end else begin
                    nx_a_left = m_a_left - 1;
                end
            end
`endif
        end

        @(posedge clock);
        m_left = nx_left; m_lock = nx_lock; m_ptr = nx_ptr;
        m_a_left = nx_a_left; m_a_route = nx_a_route;
        #1;
    endtask

    task automatic set_d(input int p, input logic [2:0] op, input logic [SIZE_W-1:0] size);
        out_d_opcode[p*3 +: 3]           = op;
        out_d_size[p*SIZE_W +: SIZE_W]   = size;
        out_d_source[p*SRC_W +: SRC_W]   = SRC_W'($urandom);
        out_d_data[p*DATA_W +: DATA_W]   = {$urandom, $urandom};
    endtask

    task automatic randomize_inputs();
        int r;
        reset        = ($urandom_range(0, 49) == 0);
        in_a_valid   = 1'($urandom);
        r            = $urandom_range(0, 2);
        in_a_opcode  = (r == 0) ? 3'd0 : (r == 1) ? 3'd1 : 3'd4;
        in_a_param   = 3'($urandom);
        in_a_size    = SIZE_W'($urandom_range(0, 6));
        in_a_source  = SRC_W'($urandom);
        in_a_address = ADDR_W'($urandom);
        in_a_mask    = BB'($urandom);
        in_a_data    = {$urandom, $urandom};
        in_a_corrupt = 1'($urandom);
        out_a_ready  = N'($urandom);
        in_d_ready   = ($urandom_range(0, 3) != 0);
        out_d_valid  = N'($urandom);
        for (int p = 0; p < N; p++) begin
            set_d(p, 3'($urandom_range(0, 1)), SIZE_W'($urandom_range(0, 6)));
        end
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        int cnt;
        n_vec = 0; n_err = 0;
        m_left = 0; m_lock = 0; m_ptr = 0; m_a_left = 0; m_a_route = 0;

        reset = 1'b1;
        in_a_valid = 1'b0; in_a_opcode = 3'd4; in_a_param = '0; in_a_size = '0;
        in_a_source = '0; in_a_address = '0; in_a_mask = '0; in_a_data = '0;
        in_a_corrupt = 1'b0; out_a_ready = '0; in_d_ready = 1'b0;
        out_d_valid = '0; out_d_opcode = '0; out_d_size = '0; out_d_source = '0; out_d_data = '0;

        @(posedge clock); #1;
        do_cycle();
        do_cycle();
        reset = 1'b0;
        do_cycle();
        chk("rst_d_valid", obs_d_valid, 1'b0);
        chk("rst_d_ready", obs_d_ready, '0);
        chk("rst_a_valid", obs_a_valid, '0);

        // Round robin between two single-beat AccessAcks
        set_d(0, 3'd0, 3'd0);
        set_d(1, 3'd0, 3'd0);
        out_d_valid = 4'b0011;
        in_d_ready  = 1'b1;
        do_cycle(); chk("rr_first_port0", obs_d_ready, 4'b0001);
        do_cycle(); chk("rr_then_port1",  obs_d_ready, 4'b0010);
        do_cycle(); chk("rr_back_port0",  obs_d_ready, 4'b0001);
        do_cycle(); chk("rr_again_port1", obs_d_ready, 4'b0010);
        out_d_valid = '0;
        do_cycle();

        // A routing: sel=3 stalls, sel=1 fires
        in_a_valid   = 1'b1;
        in_a_opcode  = 3'd4;
        out_a_ready  = 4'b0010;
        in_a_address = ADDR_W'(3 << SEL_LSB) | ADDR_W'(12'h abc);
        do_cycle();
        chk("a_sel3_stall", {obs_a_valid, obs_a_ready}, {4'b1000, 1'b0});
        in_a_address = ADDR_W'(1 << SEL_LSB);
        do_cycle();
        chk("a_sel1_fire", {obs_a_valid, obs_a_ready}, {4'b0010, 1'b1});
        in_a_valid = 1'b0;

        // 8-beat AccessAckData on port1 with port0 waiting
        set_d(1, 3'd1, 3'd6);
        set_d(0, 3'd0, 3'd0);
        out_d_valid = 4'b0010;
        cnt = 0;
        do_cycle(); if (obs_d_ready == 4'b0010) cnt++;
        out_d_valid = 4'b0011;
        for (int i = 0; i < 7; i++) begin
            set_d(1, 3'd1, 3'd6);
            do_cycle();
            if (obs_d_ready == 4'b0010 && obs_d_valid) cnt++;
        end
        chk("burst_8_beats_port1", cnt, 8);
        do_cycle();
        chk("after_burst_port0", obs_d_ready, 4'b0001);
        out_d_valid = '0;
        do_cycle();

        // Mid-burst valid drop on the locked port
        set_d(1, 3'd1, 3'd6);
        out_d_valid = 4'b0010;
        for (int i = 0; i < 3; i++) do_cycle();
        out_d_valid = 4'b0001;
        do_cycle();
        chk("drop_stall_c1", {obs_d_valid, obs_d_ready}, {1'b0, 4'b0010});
        do_cycle();
        chk("drop_stall_c2", {obs_d_valid, obs_d_ready}, {1'b0, 4'b0010});
        out_d_valid = 4'b0011;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            do_cycle();
            if (obs_d_valid && obs_d_ready == 4'b0010) cnt++;
        end
        chk("drop_resume_5_beats", cnt, 5);
        do_cycle();
        chk("drop_then_port0", obs_d_ready, 4'b0001);
        out_d_valid = '0;
        do_cycle();

        // Reset at beat 3 of 8
        set_d(1, 3'd1, 3'd6);
        out_d_valid = 4'b0010;
        for (int i = 0; i < 3; i++) do_cycle();
        reset = 1'b1;
        out_d_valid = 4'b0011;
        do_cycle();
        reset = 1'b0;
        set_d(0, 3'd0, 3'd0);
        do_cycle();
        chk("post_reset_port0_wins", obs_d_ready, 4'b0001);
        out_d_valid = '0;
        do_cycle();

        // 4-beat PutFull whose address select toggles after the first beat
        in_a_valid   = 1'b1;
        in_a_opcode  = 3'd0;
        in_a_size    = 3'd5;
        out_a_ready  = 4'b1111;
        in_a_address = '0;
        do_cycle();
        chk("put_beat0_port0", obs_a_valid, 4'b0001);
        in_a_address = ADDR_W'(1 << SEL_LSB);
        for (int i = 1; i < 4; i++) begin
            do_cycle();
`ifdef TLXBAR_A_BURST_LOCK_EN
            chk("put_locked_port0", obs_a_valid, 4'b0001);
`else
            chk("put_split_port1", obs_a_valid, 4'b0010);
`endif
        end
        do_cycle();
        chk("put_after_burst_port1", obs_a_valid, 4'b0010);
        in_a_valid = 1'b0;
        do_cycle();

        // Randomized phase
        for (int c = 0; c < 600; c++) begin
            randomize_inputs();
            do_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
